// File: rtl/islip_pkg.sv
// Shared definitions for the iSLIP scheduler: FSM encodings, width helper
// and the statistics counter width (used when ISLIP_STATS_EN is defined).
package islip_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int STAT_W = 16;

    // Ceiling log2 for elaboration-time width computation.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/islip_sched_rr_select.sv
// Programmable-priority round-robin selector: grants the first set request
// at or after ptr, wrapping modulo number_ports (also for non-power-of-2 N).
module rr_select
    import islip_pkg::*;
#(
    parameter int  number_ports = 4,
    localparam int PTR_W        = clog2(number_ports)
) (
    input  logic [number_ports-1:0] req,
    input  logic [PTR_W-1:0]        ptr,
    output logic [number_ports-1:0] gnt,
    output logic                    any
);

    logic [PTR_W:0] idx;

    // Walk the ring starting at ptr and take the first requester.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < number_ports; k++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(number_ports))
                idx = idx - (PTR_W+1)'(number_ports);
            if (!any && req[idx[PTR_W-1:0]]) begin
                gnt[idx[PTR_W-1:0]] = 1'b1;
                any                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/islip_sched.sv
// Multi-iteration iSLIP scheduler. One request/grant/accept pass per clock,
// ITERATIONS passes per round, conflict-free match presented in DONE.
// Optional ISLIP_STATS_EN adds saturating rounds/matches counters.
module islip_sched
    import islip_pkg::*;
#(
    parameter int  number_ports = 4,
    parameter int  ITERATIONS   = 2,
    localparam int PTR_W        = clog2(number_ports)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [number_ports*number_ports-1:0] request,
    output logic                            busy,
    output logic                            done,
    output logic [number_ports-1:0]         match_valid,
    output logic [number_ports*PTR_W-1:0]   destinations
`ifdef ISLIP_STATS_EN
   ,output logic [STAT_W-1:0]               rounds,
    output logic [STAT_W-1:0]               matches
`endif
);

    localparam int N = number_ports;

    state_t                    state;
    logic [N*N-1:0]            lreq;
    logic [PTR_W-1:0]          cnt;
    logic [N-1:0]              imat, omat, imat_n, omat_n, fp_v;
    logic [N-1:0][PTR_W-1:0]   wdst, wdst_n, fp_dst, gptr, aptr, a_idx;
    logic [N-1:0][N-1:0]       g_req, g_gnt, a_req, a_gnt;
    logic [N-1:0]              g_any, a_any;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == N-1) ? '0 : p + 1'b1;
    endfunction

    // Grant stage: one selector per output over still-unmatched inputs.
    for (genvar j = 0; j < N; j++) begin : g_out
        for (genvar i = 0; i < N; i++) begin : g_bit
            assign g_req[j][i] = lreq[i*N+j] & ~imat[i] & ~omat[j];
            assign a_req[i][j] = g_gnt[j][i] & g_any[j];
        end
        rr_select #(.number_ports(N)) u_gsel (
            .req(g_req[j]), .ptr(gptr[j]), .gnt(g_gnt[j]), .any(g_any[j]));
    end

    // Accept stage: one selector per input over the outputs granting it.
    for (genvar i = 0; i < N; i++) begin : g_in
        rr_select #(.number_ports(N)) u_asel (
            .req(a_req[i]), .ptr(aptr[i]), .gnt(a_gnt[i]), .any(a_any[i]));
    end

    // Fold this pass's accepts into the running match.
    always_comb begin
        a_idx  = '0;
        imat_n = imat;
        omat_n = omat;
        wdst_n = wdst;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++)
                if (a_gnt[i][j]) a_idx[i] = PTR_W'(j);
            if (a_any[i]) begin
                imat_n[i]        = 1'b1;
                omat_n[a_idx[i]] = 1'b1;
                wdst_n[i]        = a_idx[i];
            end
        end
    end

    // Round FSM, match registers and persistent round-robin pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            match_valid  <= '0;
            destinations <= '0;
            lreq         <= '0;
            cnt          <= '0;
            imat         <= '0;
            omat         <= '0;
            wdst         <= '0;
            fp_v         <= '0;
            fp_dst       <= '0;
            gptr         <= '0;
            aptr         <= '0;
        end else if (state == ITER) begin
            imat <= imat_n;
            omat <= omat_n;
            wdst <= wdst_n;
            cnt  <= cnt + 1'b1;
            // only first-pass accepts are allowed to move pointers
            if (cnt == '0) begin
                fp_v   <= a_any;
                fp_dst <= a_idx;
            end
            if (cnt == PTR_W'(ITERATIONS-1)) begin
                state        <= DONE;
                busy         <= 1'b0;
                done         <= 1'b1;
                match_valid  <= imat_n;
                destinations <= wdst_n;
            end
        end else begin
            if (state == DONE) begin
                for (int i = 0; i < N; i++)
                    if (fp_v[i]) begin
                        aptr[i]         <= ptr_inc(fp_dst[i]);
                        gptr[fp_dst[i]] <= ptr_inc(PTR_W'(i));
                    end
            end
            done  <= 1'b0;
            busy  <= start;
            state <= start ? ITER : IDLE;
            if (start) begin
                lreq <= request;
                cnt  <= '0;
                imat <= '0;
                omat <= '0;
                wdst <= '0;
            end
        end
    end

`ifdef ISLIP_STATS_EN
    logic [STAT_W:0] msum;

    // Running match total plus this round's popcount, one bit of headroom.
    always_comb begin
        msum = {1'b0, matches};
        for (int i = 0; i < N; i++)
            msum = msum + (STAT_W+1)'(match_valid[i]);
    end

    // Saturating round and match counters, advanced once per DONE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rounds  <= '0;
            matches <= '0;
        end else if (done) begin
            if (rounds != '1) rounds <= rounds + 1'b1;
            matches <= msum[STAT_W] ? '1 : msum[STAT_W-1:0];
        end
    end
`endif

endmodule

// File: doc/islip_sched.md
Name: islip_sched

Overview:
- Multi-iteration, parametrised iSLIP scheduler for the input-queued switch. It replaces the single-pass scheduler.
- Each round it latches a VOQ request matrix and runs ITERATIONS request/grant/accept passes, one pass per clock.
- It then presents a conflict-free input-to-output match that drives cross_control/crossgrid.
- Grant and accept round-robin pointers persist across rounds and use iSLIP update rules.

Parameters:
- number_ports, 4, switch radix N (≥2).
- ITERATIONS, 2, passes per round (1..N).
- PTR_W, $clog2(number_ports), localparam, port-index width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a round; sampled only in IDLE or DONE.
- request  in  N*N  bit [i*N+j] = input i has a cell for output j.
- busy  out  1  high in ITER state.
- done  out  1  one-cycle pulse, high while in DONE state.
- match_valid  out  N  bit i = input i matched this round.
- destinations  out  N*PW  field i = output matched to input i; zero when unmatched.

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, match_valid=0, destinations=0; all grant/accept pointers=0; iteration counter=0; latched request=0.
- FSM states:
  - IDLE → ITER on start=1. At that edge request is latched and the unmatched-input/output masks are cleared. Changes to request during a round are ignored.
  - ITER: each edge performs one pass on still-unmatched inputs and outputs, then counter++.
    - Grant: each unmatched output picks the first requesting unmatched input at or after its grant pointer, modulo N.
    - Accept: each unmatched input picks the first granting output at or after its accept pointer.
    - Accepted pairs are recorded in the match registers.
    - When counter reaches ITERATIONS-1, the next state is DONE.
  - DONE, one cycle: done=1. match_valid/destinations are updated at the edge entering DONE and hold until the next entry to DONE.
    - Pointers update on the edge leaving DONE, using first-pass accepts only.
    - Grant pointer of output j becomes (accepted input + 1) mod N.
    - Accept pointer of input i becomes (accepted output + 1) mod N.
    - Pairs matched in later passes do not move pointers. All passes of a round use the round-start pointers.
  - DONE → ITER if start=1 (back-to-back, new request latched); otherwise → IDLE.
- start while in ITER is ignored.
- Latency: start at edge k → done high in the cycle after edge k+ITERATIONS. Back-to-back round period is ITERATIONS+1 cycles.
- Request all zero: the round completes normally with match_valid=0, destinations=0, and pointers unchanged.
- The match is one-to-one by construction. No output appears in two destinations fields with match_valid set.
- Pointer arithmetic wraps at N-1→0. This holds for non-power-of-2 N: N=3 wraps 2→0, and the pointer value N is never produced.
- Early exit is not allowed: all ITERATIONS passes always run.

Optional Feature:
- ISLIP_STATS_EN defined: adds port rounds (out, 16) and port matches (out, 16).
  - rounds increments on each DONE cycle.
  - matches adds popcount(match_valid) at each DONE cycle.
  - Both saturate at 16'hFFFF and reset to 0.
- Not defined: the two ports and their counters are absent. Core behaviour is identical.

Decomposition:
- Package islip_pkg holds:
  - state encodings IDLE=2'd0, ITER=2'd1, DONE=2'd2;
  - a clog2 helper function;
  - the saturating-counter width constant STAT_W=16.
- Sub-module rr_select(number_ports): programmable-priority round-robin selector. Inputs req[N] and ptr[PW]; outputs gnt[N] one-hot and any.
  - Combinational; instantiated N times for grant and N times for accept.
- islip_sched holds the FSM, match and pointer registers.

Test Plan (N=4):
- Reset, ITERATIONS=2, request=16'hFFFF, start → done after 3 cycles.
  - Round 1: match_valid=4'b0011, dest[0]=0, dest[1]=1.
  - Same request, round 2: match_valid=4'b0111, dest[0]=1, dest[1]=0, dest[2]=2.
- ITERATIONS=4, reset, request=16'hFFFF, start → match_valid=4'hF, dest[i]=i for all i.
- request=0, start → done pulse, match_valid=0. A following full-request round matches round 1 of the first scenario, confirming pointers are unchanged.
- start held high continuously → done every ITERATIONS+1 cycles; busy=0 only during DONE cycles. start pulses during ITER produce no extra round.
- reset asserted mid-ITER → outputs and pointers immediately 0, FSM in IDLE. A next round with 16'hFFFF reproduces round 1 of the first scenario.
- ISLIP_STATS_EN: run the first two rounds of the first scenario → rounds=2, matches=5. Forcing rounds to 16'hFFFF and running one more round leaves it at 16'hFFFF.
